// File: rtl/shift_left_seq.sv
// rtl/shift_left_seq.sv - sequential 50-bit left digit shifter with valid/ready ports
// One digit is shifted per clock, so a request costs shift+2 cycles with no backpressure.
module shift_left_seq #(
  parameter int WIDTH     = 50,
  parameter int DIGIT     = 5,
  parameter int MAX_SHIFT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_i,
  input  logic [2:0]       shift_i,
  input  logic [DIGIT-1:0] fill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             out_err_o
);

  localparam int         NDIG      = WIDTH / DIGIT;
  localparam logic [2:0] MAX_SHIFT_L = 3'(MAX_SHIFT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [DIGIT-1:0]   fill_q, fill_d;
  logic               err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          data_d = in_i;
          fill_d = fill_i;
          cnt_d  = shift_i;
          if (shift_i == 3'd0) begin
            state_d = DONE;
          end else if (shift_i > MAX_SHIFT_L) begin
            // Illegal counts flag an error and return an all-fill word.
            data_d  = {NDIG{fill_i}};
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = {data_q[WIDTH-DIGIT-1:0], fill_q};
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == DONE);
  assign out_o       = data_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// tb/tb_shift_left_seq.sv - self-checking bench for shift_left_seq
// Expected words come from the arithmetic definition of a digit shift with fill.
module tb_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] din;
  logic [2:0]  shift;
  logic [4:0]  fill;
  logic        out_valid;
  logic        out_ready;
  logic [49:0] dout;
  logic        out_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  shift_left_seq dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_i       (din),
    .shift_i    (shift),
    .fill_i     (fill),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_o      (dout),
    .out_err_o  (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [49:0] ref_out(input logic [49:0] d, input int k, input logic [4:0] f);
    logic [49:0] rep;
    rep = {10{f}};
    if (k > 4) return rep;
    return (d << (5 * k)) | (rep & ((50'd1 << (5 * k)) - 50'd1));
  endfunction

  function automatic logic [49:0] rand50();
    return {$urandom_range(262143, 0), $urandom()};
  endfunction

  // Drives one request, scrambles inputs after accept, waits for the result, optionally holds it.
  task automatic run_req(input logic [49:0] d, input logic [2:0] k, input logic [4:0] f,
                         input int hold, output logic [49:0] o, output logic e, output int lat,
                         output logic stable, output int acc_cyc, output logic rdy);
    din = d; shift = k; fill = f; in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; din = rand50(); fill = ~f; shift = 3'($urandom_range(7, 0));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    o = dout; e = out_err; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (dout !== o || out_err !== e || out_valid !== 1'b1) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0; shift = '0; fill = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (dout !== 50'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", dout); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", out_err); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [49:0] o; logic e, st, rdy; int lat, ac;
    run_req(50'h000000000001F, 3'd2, 5'h03, 0, o, e, lat, st, ac, rdy);
    checks++; if (o !== 50'h0000000007C63) begin failures++; $display("FAIL dir_k2_out got=%h exp=%h", o, 50'h0000000007C63); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL dir_k2_err got=%0b exp=0", e); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL dir_k2_latency got=%0d exp=3", lat); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir_k2_ready_after got=%0b exp=1", in_ready); end
    run_req(50'h123456789ABCD, 3'd0, 5'h1F, 0, o, e, lat, st, ac, rdy);
    checks++; if (o !== 50'h123456789ABCD) begin failures++; $display("FAIL dir_k0_out got=%h exp=%h", o, 50'h123456789ABCD); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL dir_k0_latency got=%0d exp=1", lat); end
    run_req(50'h3FFFFFFFFFFFF, 3'd4, 5'h00, 0, o, e, lat, st, ac, rdy);
    checks++; if (o !== 50'h3FFFFFFF00000) begin failures++; $display("FAIL dir_k4_out got=%h exp=%h", o, 50'h3FFFFFFF00000); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL dir_k4_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_illegal();
    logic [49:0] o; logic e, st, rdy; int lat, ac;
    run_req(rand50(), 3'd5, 5'h15, 1, o, e, lat, st, ac, rdy);
    checks++; if (o !== 50'h2B5AD6B5AD6B5) begin failures++; $display("FAIL illegal_out got=%h exp=%h", o, 50'h2B5AD6B5AD6B5); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL illegal_err got=%0b exp=1", e); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL illegal_err_cleared got=%0b exp=0", out_err); end
  endtask

  task automatic test_backpressure();
    logic [49:0] a, b, exp_a;
    a = rand50(); b = rand50();
    exp_a = ref_out(a, 1, 5'h0A);
    din = a; shift = 3'd1; fill = 5'h0A; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    din = b; shift = 3'd0; fill = 5'h11;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || dout !== exp_a) begin failures++; $display("FAIL bp_first got=%h/%0b exp=%h/1", dout, out_valid, exp_a); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (dout !== exp_a) begin failures++; $display("FAIL bp_hold_out[%0d] got=%h exp=%h", i, dout, exp_a); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_hs valid=%0b ready=%0b exp=0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== b) begin failures++; $display("FAIL bp_second got=%h/%0b exp=%h/1", dout, out_valid, b); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_one_result got=%0b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [49:0] d, o, exp; logic [2:0] k; logic [4:0] f; logic e, st, rdy; int lat, ac, h;
    for (int i = 0; i < 40; i++) begin
      d = rand50(); k = 3'($urandom_range(7, 0)); f = 5'($urandom_range(31, 0)); h = $urandom_range(2, 0);
      exp = ref_out(d, int'(k), f);
      run_req(d, k, f, h, o, e, lat, st, ac, rdy);
      checks++; if (o !== exp || e !== (k > 3'd4)) begin failures++; $display("FAIL rand_out[%0d] k=%0d got=%h/%0b exp=%h/%0b", i, k, o, e, exp, k > 3'd4); end
      checks++; if (lat !== ((k > 3'd4) ? 1 : int'(k) + 1)) begin failures++; $display("FAIL rand_latency[%0d] k=%0d got=%0d", i, k, lat); end
      checks++; if (st !== 1'b1 || rdy !== 1'b1) begin failures++; $display("FAIL rand_stable[%0d] stable=%0b ready=%0b exp=1/1", i, st, rdy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [49:0] o; logic e, st, rdy; int lat, ac, prev, pk;
    prev = -1; pk = 0;
    for (int i = 0; i < 6; i++) begin
      int k;
      k = i % 5;
      run_req(rand50(), 3'(k), 5'($urandom_range(31, 0)), 0, o, e, lat, st, ac, rdy);
      if (prev >= 0) begin
        checks++; if (ac - prev !== pk + 2) begin failures++; $display("FAIL b2b_period[%0d] got=%0d exp=%0d", i, ac - prev, pk + 2); end
      end
      prev = ac; pk = k;
    end
  endtask

  task automatic test_reset_mid();
    logic [49:0] d, o; logic e, st, rdy; int lat, ac;
    din = 50'h2AAAAAAAAAAAA; shift = 3'd4; fill = 5'h1F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || dout !== 50'd0 || in_ready !== 1'b0 || out_err !== 1'b0) begin
      failures++; $display("FAIL mid_reset valid=%0b out=%h ready=%0b err=%0b exp=0/0/0/0", out_valid, dout, in_ready, out_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%0b exp=1", in_ready); end
    d = rand50();
    run_req(d, 3'd1, 5'h06, 0, o, e, lat, st, ac, rdy);
    checks++; if (o !== ref_out(d, 1, 5'h06) || e !== 1'b0 || lat !== 2) begin
      failures++; $display("FAIL mid_reset_fresh got=%h/%0b lat=%0d exp=%h/0 lat=2", o, e, lat, ref_out(d, 1, 5'h06)); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
